// File: rtl/nios_lcd_controller_if.sv
// -----------------------------------------------------------------------------
// nios_lcd_controller_if
// Avalon-MM slave bus bundle between the Nios II data master and the LCD
// sequencer.
//   address    [1:0]  register select
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] read data (slave drives, combinational from address)
// -----------------------------------------------------------------------------
interface nios_lcd_controller_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/nios_lcd_controller.sv
// -----------------------------------------------------------------------------
// nios_lcd_controller
// Avalon-MM slave that sequences byte writes to an HD44780-compatible
// character LCD in 8-bit mode. Software posts command (addr 0) or data
// (addr 1) bytes into a 4-entry FIFO; a small FSM drives setup, enable pulse,
// hold and execution-wait timing for each byte.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   bus        Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata)
//   lcd_data   LCD DB[7:0]
//   lcd_rs     register select (0 command, 1 data)
//   lcd_rw     read/write, tied to write
//   lcd_en     LCD enable strobe (registered)
//
// Register map:
//   0 W  push command byte writedata[7:0]
//   1 W  push data byte writedata[7:0]
//   2 R  status: [0] busy [1] full [2] empty [3] overflow [6:4] count
//   3 W  control: [0] flush FIFO, [1] clear overflow
// -----------------------------------------------------------------------------
module nios_lcd_controller #(
  parameter int SETUP_CYC    = 2,
  parameter int PULSE_CYC    = 12,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int CNT_W        = 17
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_lcd_controller_if.slave    bus,
  output logic [7:0]              lcd_data,
  output logic                    lcd_rs,
  output logic                    lcd_rw,
  output logic                    lcd_en
);

  // Counter reload values: each phase lasts exactly its parameter count.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  // FSM / output registers
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             lcd_en_q;
  logic             lcd_rs_q;
  logic [7:0]       lcd_data_q;

  // FIFO storage and bookkeeping
  logic [8:0] mem_q [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] count_q,  count_d;
  logic       ovf_q,    ovf_d;

  // Bus decode
  logic wr_stb;
  logic push_req;
  logic ctrl_wr;
  logic flush;
  logic ovf_clr;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic push_drop;
  logic busy;
  logic is_clr_cmd;
  logic [8:0] head;

  // Upper write-data bits carry no meaning for this block.
  logic unused_wdata;
  assign unused_wdata = ^bus.writedata[31:8];

  assign wr_stb   = bus.chipselect & ~bus.write_n;
  assign push_req = wr_stb & ~bus.address[1];
  assign ctrl_wr  = wr_stb & (bus.address == 2'd3);
  assign flush    = ctrl_wr & bus.writedata[0];
  assign ovf_clr  = ctrl_wr & bus.writedata[1];

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign head       = mem_q[rd_ptr_q];

  // A flush discards everything not yet on the pins, including the head
  // that would otherwise be popped on this same edge.
  assign pop       = (state_q == S_IDLE) & ~fifo_empty & ~flush;
  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // still accepted when the head leaves at the same time.
  assign push      = push_req & ~flush & (~fifo_full | pop);
  assign push_drop = push_req & ~flush & fifo_full & ~pop;

  assign busy = (state_q != S_IDLE) | ~fifo_empty;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_clr_cmd = ~lcd_rs_q & (lcd_data_q[7:2] == 6'd0) &
                      (lcd_data_q[1:0] != 2'd0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Set wins over clear so an overflow in the clearing cycle is not lost.
    ovf_d    = (ovf_q & ~ovf_clr) | push_drop;
    if (flush) begin
      rd_ptr_d = 2'd0;
      wr_ptr_d = 2'd0;
      count_d  = 3'd0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.address[0], bus.writedata[7:0]};
  end

  // Byte sequencer. lcd_rs/lcd_data only change on a pop, so they are stable
  // through setup, pulse, hold and wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lcd_en_q   <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            lcd_rs_q   <= head[8];
            lcd_data_q <= head[7:0];
            cnt_q      <= SETUP_LD;
            state_q    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            lcd_en_q <= 1'b1;
            cnt_q    <= PULSE_LD;
            state_q  <= S_PULSE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            lcd_en_q <= 1'b0;
            cnt_q    <= HOLD_LD;
            state_q  <= S_HOLD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            cnt_q   <= is_clr_cmd ? CLR_LD : CMD_LD;
            state_q <= S_WAIT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          lcd_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.readdata = 32'd0;
    if (bus.address == 2'd2) begin
      bus.readdata[6:0] = {count_q, ovf_q, fifo_empty, fifo_full, busy};
    end
  end

  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_nios_lcd_controller.sv
// -----------------------------------------------------------------------------
// tb_nios_lcd_controller
// Self-checking bench for nios_lcd_controller with shortened wait times.
// Single-byte transactions come from a vector table; multi-cycle corner cases
// (overflow, flush, asynchronous reset, full FIFO push+pop) are hand-written.
// A monitor pops the expected {rs,data} at every rising lcd_en and checks
// pulse width and bus stability during the pulse.
// -----------------------------------------------------------------------------
module tb_nios_lcd_controller;
  localparam int SETUP = 2;
  localparam int PULSE = 12;
  localparam int HOLD  = 2;
  localparam int CMDW  = 40;
  localparam int CLRW  = 150;
  localparam int POP_EDGE = 2 + SETUP + PULSE + HOLD + CMDW;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;

  nios_lcd_controller_if bus_if ();

  nios_lcd_controller #(
    .SETUP_CYC    (SETUP),
    .PULSE_CYC    (PULSE),
    .HOLD_CYC     (HOLD),
    .CMD_WAIT_CYC (CMDW),
    .CLR_WAIT_CYC (CLRW),
    .CNT_W        (17)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rises = 0;
  logic [8:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor on the LCD pins.
  logic       en_prev = 1'b0;
  int         plen = 0;
  logic [8:0] lat_bus;
  logic       stable;
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_prev = 1'b0;
      plen    = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        rises++;
        lat_bus = {lcd_rs, lcd_data};
        stable  = 1'b1;
        plen    = 1;
        if (sb.size() == 0) begin
          check("unexpected_pulse", {23'd0, lat_bus}, 32'h1ff);
        end else begin
          check("sb_byte", {23'd0, lat_bus}, {23'd0, sb.pop_front()});
        end
      end else if (lcd_en) begin
        plen++;
        if ({lcd_rs, lcd_data} !== lat_bus) stable = 1'b0;
      end else if (en_prev) begin
        check("pulse_len", plen, PULSE);
        check("stable_in_pulse", {31'd0, stable}, 32'd1);
      end
      en_prev = lcd_en;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = 2'd2;
    bus_if.writedata  = 32'd0;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    bus_if.address = 2'd2;
    #1;
    check(name, bus_if.readdata, exp);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    bus_if.address = 2'd2;
    #1;
    while (bus_if.readdata[0] && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, bus_if.readdata[0]}, 32'd0);
  endtask

  task automatic wait_en(input int bound);
    int n = 0;
    while (!lcd_en && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("en_timeout", {31'd0, lcd_en}, 32'd1);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        rs;
    logic [7:0]  data;
    int          wait_cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int k;
    int j;
    int r0;

    vecs[0] = '{2'd0, 32'h0000_0038, 1'b0, 8'h38, CMDW};
    vecs[1] = '{2'd1, 32'h0000_0041, 1'b1, 8'h41, CMDW};
    vecs[2] = '{2'd0, 32'h0000_0001, 1'b0, 8'h01, CLRW};
    vecs[3] = '{2'd0, 32'hFFFF_FF02, 1'b0, 8'h02, CLRW};
    vecs[4] = '{2'd0, 32'h0000_0003, 1'b0, 8'h03, CLRW};
    vecs[5] = '{2'd1, 32'h0000_0001, 1'b1, 8'h01, CMDW};
    vecs[6] = '{2'd0, 32'h0000_0004, 1'b0, 8'h04, CMDW};
    vecs[7] = '{2'd0, 32'hABCD_1280, 1'b0, 8'h80, CMDW};

    bus_idle();
    repeat (3) @(negedge clk);
    check("rst_en", {31'd0, lcd_en}, 32'd0);
    check("rst_data", {24'd0, lcd_data}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_status("rst_status", 32'h04);
    check("rw_tied", {31'd0, lcd_rw}, 32'd0);
    bus_if.address = 2'd0;
    #1;
    check("read_addr0", bus_if.readdata, 32'd0);

    // Table of single-byte transactions
    for (int v = 0; v < 8; v++) begin
      wait_idle(5000);
      sb.push_back({vecs[v].rs, vecs[v].data});
      wr(vecs[v].addr, vecs[v].wdata);
      bus_idle();
      @(negedge clk);
      check($sformatf("v%0d_data", v), {24'd0, lcd_data}, {24'd0, vecs[v].data});
      check($sformatf("v%0d_rs", v), {31'd0, lcd_rs}, {31'd0, vecs[v].rs});
      k = 1;
      while (!lcd_en && k < 100) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("v%0d_rise_lat", v), k, SETUP + 1);
      k = 0;
      while (lcd_en && k < 100) begin
        @(negedge clk);
        k++;
      end
      #1;
      j = 0;
      while (bus_if.readdata[0] && j < 5000) begin
        @(negedge clk);
        #1;
        j++;
      end
      check($sformatf("v%0d_fall_to_idle", v), j, HOLD + vecs[v].wait_cyc);
      check_status($sformatf("v%0d_status", v), 32'h04);
    end

    // Overflow: one byte in flight, five more back-to-back
    wait_idle(5000);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) sb.push_back({1'b0, 8'hA0 + 8'(i)});
      wr(2'd0, 32'hA0 + i);
    end
    bus_idle();
    check_status("ovf_status", 32'h4B);
    wr(2'd3, 32'd2);
    bus_idle();
    check_status("ovf_cleared", 32'h43);
    wait_idle(5000);
    check("ovf_sb_drained", sb.size(), 0);
    check_status("ovf_end_status", 32'h04);

    // Flush during the first byte's pulse
    wait_idle(5000);
    sb.push_back({1'b0, 8'hB0});
    wr(2'd0, 32'hB0);
    wr(2'd0, 32'hB1);
    wr(2'd0, 32'hB2);
    bus_idle();
    wait_en(100);
    wr(2'd3, 32'd1);
    bus_idle();
    check_status("flush_status", 32'h05);
    r0 = rises;
    wait_idle(5000);
    repeat (100) @(negedge clk);
    check("flush_no_pulse", rises - r0, 0);
    check_status("flush_end_status", 32'h04);

    // Asynchronous reset mid-pulse
    wait_idle(5000);
    sb.push_back({1'b1, 8'h5A});
    wr(2'd1, 32'h5A);
    bus_idle();
    wait_en(100);
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_en", {31'd0, lcd_en}, 32'd0);
    check("arst_rs", {31'd0, lcd_rs}, 32'd0);
    check("arst_data", {24'd0, lcd_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    r0 = rises;
    check_status("arst_status", 32'h04);
    repeat (100) @(negedge clk);
    check("arst_no_pulse", rises - r0, 0);

    // Full FIFO popping in IDLE while a push lands on the same edge
    wait_idle(5000);
    for (int i = 0; i < 5; i++) begin
      sb.push_back({1'b1, 8'h61 + 8'(i)});
      wr(2'd1, 32'h61 + i);
    end
    bus_idle();
    check_status("full_status", 32'h43);
    repeat (POP_EDGE - 5) @(negedge clk);
    sb.push_back({1'b1, 8'h66});
    wr(2'd1, 32'h66);
    bus_idle();
    check_status("full_pushpop_status", 32'h43);
    wait_idle(5000);
    check("full_sb_drained", sb.size(), 0);
    check_status("full_end_status", 32'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
